// File: rtl/fractal_sync_pkg.sv
// ============================================================================
// fractal_sync_pkg -- shared constants and helpers for the fractal_sync RFs.
// Revision: 2.0 - counting-barrier generation
// ============================================================================
`default_nettype none

package fractal_sync_pkg;

    // Entry state encoding: an entry is armed exactly while its count is non-zero
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    function automatic int unsigned reg_idx_width(input int unsigned n_regs);
        return (n_regs > 1) ? $clog2(n_regs) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fractal_sync_cnt_entry.sv
// ============================================================================
// fractal_sync_cnt_entry -- one saturating arrival counter with latched threshold.
// Revision: 2.0 - counting-barrier generation
// ============================================================================
`default_nettype none

module fractal_sync_cnt_entry
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned HIT_W     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [HIT_W-1:0]     hits,
    input  logic [CNT_WIDTH-1:0] first_thr,
    input  logic [N_PORTS-1:0]   mask,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic [CNT_WIDTH-1:0] thr_eff,
    output logic                 complete,
    output logic                 overshoot
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] thr;
    } entry_state_t;

    entry_state_t     r_state;
    entry_state_t     w_state_d;
    logic [0:0]       w_fsm;
    logic             w_any;
    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_fsm     = (r_state.cnt != '0) ? ST_ARMED : ST_IDLE;
        w_any     = |mask;
        thr_eff   = (w_fsm == ST_ARMED) ? r_state.thr : first_thr;
        w_sum     = {1'b0, r_state.cnt} + SUM_W'(hits);
        complete  = w_any && (w_sum >= {1'b0, thr_eff});
        overshoot = w_any && (w_sum >  {1'b0, thr_eff});

        w_state_d = r_state;
        if (complete) begin
            w_state_d = '0;
        end else if (w_any) begin
            // Below threshold, so the sum always fits back into the counter
            w_state_d.cnt = w_sum[CNT_WIDTH-1:0];
            w_state_d.thr = thr_eff;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= '0;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign cnt = r_state.cnt;

endmodule

`default_nettype wire

// File: rtl/fractal_sync_cnt_rf.sv
// ============================================================================
// fractal_sync_cnt_rf -- multi-port counting-barrier register file.
// Revision: 2.0 - counting-barrier generation
// ============================================================================
`default_nettype none

module fractal_sync_cnt_rf
    import fractal_sync_pkg::*;
#(
    parameter int unsigned N_REGS    = 2,
    parameter int unsigned IDX_WIDTH = 1,
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_PORTS-1:0]                  check_i,
    input  logic [N_PORTS-1:0][IDX_WIDTH-1:0]   idx_i,
    input  logic [N_PORTS-1:0]                  idx_valid_i,
    input  logic [N_PORTS-1:0][CNT_WIDTH-1:0]   thr_i,
    output logic [N_PORTS-1:0]                  present_o,
    output logic [N_PORTS-1:0][CNT_WIDTH-1:0]   count_o,
    output logic [N_PORTS-1:0]                  done_o,
    output logic [N_REGS-1:0]                   release_o,
    output logic [N_PORTS-1:0]                  error_o
);

    localparam int unsigned RIW   = reg_idx_width(N_REGS);
    localparam int unsigned HIT_W = $clog2(N_PORTS + 1);

    if ((2 ** IDX_WIDTH) < N_REGS) begin : g_bad_idx_width
        $fatal(1, "IDX_WIDTH too small for N_REGS");
    end
    if ((2 ** CNT_WIDTH) - 1 < N_PORTS) begin : g_bad_cnt_width
        $fatal(1, "CNT_WIDTH too small for N_PORTS");
    end

    logic [N_PORTS-1:0]                w_arrive;
    logic [N_PORTS-1:0]                w_in_range;
    logic [N_PORTS-1:0][RIW-1:0]       w_ridx;
    logic [N_PORTS-1:0][CNT_WIDTH-1:0] w_thr_map;
    logic [N_REGS-1:0][CNT_WIDTH-1:0]  w_cnt;
    logic [N_REGS-1:0][CNT_WIDTH-1:0]  w_thr_eff;
    logic [N_REGS-1:0]                 w_complete;
    logic [N_REGS-1:0]                 w_overshoot;
    logic [N_PORTS-1:0]                w_done_d;
    logic [N_PORTS-1:0]                w_err_d;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            w_arrive[i]   = check_i[i] & idx_valid_i[i];
            w_ridx[i]     = idx_i[i][RIW-1:0];
            w_in_range[i] = (32'(w_ridx[i]) < N_REGS);
            w_thr_map[i]  = (thr_i[i] == '0) ? CNT_WIDTH'(1) : thr_i[i];
        end
    end

    for (genvar j = 0; j < N_REGS; j++) begin : g_entry
        logic [N_PORTS-1:0]   mask;
        logic [HIT_W-1:0]     hits;
        logic [CNT_WIDTH-1:0] first_thr;

        // Descending scan so the lowest-numbered arriving port supplies first_thr
        always_comb begin
            mask      = '0;
            hits      = '0;
            first_thr = '0;
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (w_arrive[i] && w_in_range[i] && (32'(w_ridx[i]) == j)) begin
                    mask[i]   = 1'b1;
                    hits      = hits + HIT_W'(1);
                    first_thr = w_thr_map[i];
                end
            end
        end

        fractal_sync_cnt_entry #(
            .N_PORTS   (N_PORTS),
            .CNT_WIDTH (CNT_WIDTH),
            .HIT_W     (HIT_W)
        ) u_entry (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .hits      (hits),
            .first_thr (first_thr),
            .mask      (mask),
            .cnt       (w_cnt[j]),
            .thr_eff   (w_thr_eff[j]),
            .complete  (w_complete[j]),
            .overshoot (w_overshoot[j])
        );
    end

    always_comb begin
        present_o = '0;
        count_o   = '0;
        w_done_d  = '0;
        w_err_d   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_arrive[i] && w_in_range[i]) begin
                count_o[i]   = w_cnt[w_ridx[i]];
                present_o[i] = |w_cnt[w_ridx[i]];
                w_done_d[i]  = w_complete[w_ridx[i]];
                w_err_d[i]   = w_overshoot[w_ridx[i]] |
                               (w_thr_map[i] != w_thr_eff[w_ridx[i]]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o    <= '0;
            release_o <= '0;
            error_o   <= '0;
        end else begin
            done_o    <= w_done_d;
            release_o <= w_complete;
            error_o   <= w_err_d;
        end
    end

endmodule

`default_nettype wire
